// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, common command bytes and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        RELEASE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_BREAK       = 8'hF0;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 pin conditioning: 2-flop synchronizers, all-taps-agree clock filter and a
// one-cycle fall_tick on each filtered clock high-to-low transition.
module ps2_edge_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic ps2c_filt,
    output logic ps2d_sync,
    output logic fall_tick
);

    logic [1:0]            c_sync_q, c_sync_d;
    logic [1:0]            d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] shift_q, shift_d;
    logic                  filt_q, filt_d;
    logic                  fall_q, fall_d;

    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c_in};
        d_sync_d = {d_sync_q[0], ps2d_in};
        shift_d  = {shift_q[FILTER_LEN-2:0], c_sync_q[1]};
        filt_d   = filt_q;
        // Decide on the post-shift taps so the filtered level moves on the same edge the last tap fills.
        if (shift_d == '1) begin
            filt_d = 1'b1;
        end else if (shift_d == '0) begin
            filt_d = 1'b0;
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            shift_q  <= '1;
            filt_q   <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            shift_q  <= shift_d;
            filt_q   <= filt_d;
            fall_q   <= fall_d;
        end
    end

    assign ps2c_filt = filt_q;
    assign ps2d_sync = d_sync_q[1];
    assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocked-out byte with odd
// parity, device ACK check, bus-release wait and an inter-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned RTS_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(INHIBIT_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

    logic ps2c_filt;
    logic ps2d_sync;
    logic fall_tick;

    ps2_edge_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge_filter (
        .clk      (clk),
        .rst      (reset),
        .ps2c_in  (ps2c_in),
        .ps2d_in  (ps2d_in),
        .ps2c_filt(ps2c_filt),
        .ps2d_sync(ps2d_sync),
        .fall_tick(fall_tick)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             parity_q, parity_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [RTS_W-1:0] rts_cnt_q, rts_cnt_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             ps2c_oe_q, ps2c_oe_d;
    logic             ps2d_oe_q, ps2d_oe_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;
    logic             bus_phase;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        rts_cnt_d = rts_cnt_q;
        wdt_d     = wdt_q;
        tx_busy_d = tx_busy_q;
        tx_done_d = 1'b0;
        tx_err_d  = 1'b0;
        bus_phase = (state_q != IDLE) && (state_q != RTS);

        if (tx_done_q || tx_err_q) begin
            tx_busy_d = 1'b0;
        end

        if (bus_phase) begin
            wdt_d = fall_tick ? '0 : wdt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A request landing on the completion pulse cycle is dropped, not queued.
                if (wr_ps2 && !tx_done_q && !tx_err_q) begin
                    shreg_d   = din;
                    parity_d  = odd_parity(din);
                    bit_idx_d = '0;
                    rts_cnt_d = '0;
                    wdt_d     = '0;
                    tx_busy_d = 1'b1;
                    state_d   = RTS;
                end
            end
            RTS: begin
                if (rts_cnt_q == RTS_LAST) begin
                    wdt_d   = '0;
                    state_d = START;
                end else begin
                    rts_cnt_d = rts_cnt_q + 1'b1;
                end
            end
            START: begin
                if (fall_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (fall_tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_tick) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (fall_tick) begin
                    if (ps2d_sync) begin
                        tx_err_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (ps2d_sync && ps2c_filt) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog overrides any same-cycle completion so done and err stay exclusive.
        if (bus_phase && !fall_tick && (wdt_q == WDT_LAST)) begin
            tx_done_d = 1'b0;
            tx_err_d  = 1'b1;
            state_d   = IDLE;
        end

        ps2c_oe_d = (state_d == RTS);
        case (state_d)
            START:   ps2d_oe_d = 1'b1;
            DATA:    ps2d_oe_d = ~shreg_d[0];
            PARITY:  ps2d_oe_d = ~parity_d;
            default: ps2d_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            rts_cnt_q <= '0;
            wdt_q     <= '0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            rts_cnt_q <= rts_cnt_d;
            wdt_q     <= wdt_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
            tx_err_q  <= tx_err_d;
        end
    end

    assign ps2c_oe = ps2c_oe_q;
    assign ps2d_oe = ps2d_oe_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;
    assign tx_err  = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain keyboard model (device clock
// scaled to HALF system cycles per half-period to keep runs short).
module tb_ps2_host_tx;

    localparam int unsigned INHIBIT = 50;
    localparam int unsigned FLEN    = 4;
    localparam int unsigned TOUT    = 400;
    localparam int unsigned HALF    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe;
    logic       tx_busy, tx_done, tx_err;

    logic dev_clk, dev_data, glitch;

    assign ps2c_in = ~ps2c_oe & dev_clk & ~glitch;
    assign ps2d_in = ~ps2d_oe & dev_data;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .FILTER_LEN    (FLEN),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_ps2 (wr_ps2),
        .din    (din),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err (tx_err)
    );

    typedef struct {
        bit          is_err;
        bit          chk_frame;
        logic [7:0]  data;
        logic        par;
        bit          chk_time;
        int unsigned err_cyc;
    } exp_t;

    exp_t exp_q[$];

    int assertions = 0;
    int failures   = 0;

    logic       rx_start, rx_par, rx_stop;
    logic [7:0] rx_byte;
    int unsigned last_fall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input bit is_err, input bit chk_frame, input logic [7:0] data,
                        input logic par, input bit chk_time, input int unsigned err_cyc);
        exp_t e;
        e.is_err    = is_err;
        e.chk_frame = chk_frame;
        e.data      = data;
        e.par       = par;
        e.chk_time  = chk_time;
        e.err_cyc   = err_cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: consumes one expectation per completion pulse, plus RTS framing checks.
    exp_t        mon_e;
    int unsigned rts_len;
    bit          post_pulse;
    initial begin
        rts_len    = 0;
        post_pulse = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rts_len    = 0;
                post_pulse = 0;
            end else begin
                if (post_pulse) begin
                    check("busy_after_pulse", 32'(tx_busy), 32'(0));
                    check("pulse_one_cycle", 32'(tx_done | tx_err), 32'(0));
                    post_pulse = 0;
                end else if (tx_done || tx_err) begin
                    check("done_err_exclusive", 32'(tx_done & tx_err), 32'(0));
                    check("busy_during_pulse", 32'(tx_busy), 32'(1));
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'({tx_done, tx_err}), 32'(0));
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("outcome_err", 32'(tx_err), 32'(mon_e.is_err));
                        if (mon_e.is_err)
                            check("err_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'(0));
                        if (mon_e.chk_frame) begin
                            check("start_bit", 32'(rx_start), 32'(0));
                            check("data_byte", 32'(rx_byte), 32'(mon_e.data));
                            check("parity_bit", 32'(rx_par), 32'(mon_e.par));
                            check("stop_bit", 32'(rx_stop), 32'(1));
                        end
                        if (mon_e.chk_time)
                            check("timeout_cycle", 32'(cyc), 32'(mon_e.err_cyc));
                    end
                    post_pulse = 1;
                end
                if (ps2c_oe) begin
                    if (rts_len == 0) check("busy_with_rts", 32'(tx_busy), 32'(1));
                    rts_len++;
                end else if (rts_len != 0) begin
                    check("rts_length", 32'(rts_len), 32'(INHIBIT));
                    check("start_drive_on_release", 32'(ps2d_oe), 32'(1));
                    rts_len = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Keyboard model: n_falls clock pulses; data sampled on rising edges.
    // The host samples ACK on the fall after the STOP-state fall, so the model
    // pulls data low after the stop bit and holds it through both remaining falls.
    task automatic device_frame(input int n_falls, input bit ack, input bit glitch_on,
                                input bit poke, input bit abort);
        bit ok;
        rx_start = 1'bx;
        rx_byte  = 'x;
        rx_par   = 1'bx;
        rx_stop  = 1'bx;
        ok = 0;
        for (int i = 0; i < int'(INHIBIT) + 50; i++) begin
            @(negedge clk);
            if (ps2c_oe) begin ok = 1; break; end
        end
        if (!ok) begin check("wait_rts_start", 32'(ps2c_oe), 32'(1)); return; end
        ok = 0;
        for (int i = 0; i < int'(INHIBIT) + 50; i++) begin
            @(negedge clk);
            if (!ps2c_oe) begin ok = 1; break; end
        end
        if (!ok) begin check("wait_rts_end", 32'(ps2c_oe), 32'(0)); return; end
        rx_start = ps2d_in;
        repeat (HALF) @(negedge clk);
        for (int f = 1; f <= n_falls; f++) begin
            dev_clk   = 1'b0;
            last_fall = cyc;
            if (poke && f == 4) begin
                din    = ps2_pkg::PS2_CMD_RESET;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else if (abort && f == 5) begin
                repeat (5) @(negedge clk);
                #2 reset = 1'b1;
                #1 check("reset_async_outputs", 32'({ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err}), 32'(0));
                @(negedge clk);
                dev_clk = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk = 1'b1;
            if (f <= 8) rx_byte[f-1] = ps2d_in;
            else if (f == 9) rx_par = ps2d_in;
            else if (f == 10) rx_stop = ps2d_in;
            for (int c = 0; c < int'(HALF); c++) begin
                @(negedge clk);
                glitch = 1'b0;
                if (c == int'(HALF) / 2) begin
                    if (glitch_on && f == 3) glitch = 1'b1;
                    if (ack && f == 10) dev_data = 1'b0;
                end
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            check("pending_outcomes", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_time_limit: run still active at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        wr_ps2   = 1'b0;
        din      = '0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        glitch   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err}), 32'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED, bits LSB-first 1,0,1,1,0,1,1,1: six ones -> parity 1
        push(0, 1, 8'hED, 1'b1, 0, 0);
        send(ps2_pkg::PS2_CMD_SET_LED);
        device_frame(12, 1, 0, 0, 0);
        wait_drain();

        push(0, 1, 8'h00, 1'b1, 0, 0);
        send(8'h00);
        device_frame(12, 1, 0, 0, 0);
        wait_drain();

        push(0, 1, 8'h01, 1'b0, 0, 0);
        send(8'h01);
        device_frame(12, 1, 0, 0, 0);
        wait_drain();

        // No ACK: 0xFF has eight ones -> parity 1, outcome error
        push(1, 1, 8'hFF, 1'b1, 0, 0);
        send(ps2_pkg::PS2_CMD_RESET);
        device_frame(12, 0, 0, 0, 0);
        wait_drain();

        // Device stops after 5 falls: error lands 2+FLEN (pin to tick) + 1 + TOUT cycles later
        send(ps2_pkg::PS2_CMD_SET_LED);
        device_frame(5, 0, 0, 0, 0);
        push(1, 0, 8'h00, 1'b0, 1, last_fall + 3 + FLEN + TOUT);
        wait_drain();

        // 0xF4 (five ones -> parity 0) with a 0xFF request injected mid-frame
        push(0, 1, 8'hF4, 1'b0, 0, 0);
        send(ps2_pkg::PS2_CMD_ENABLE);
        device_frame(12, 1, 0, 1, 0);
        wait_drain();

        // 0xFA (six ones -> parity 1) with a one-cycle clock glitch in the data phase
        push(0, 1, 8'hFA, 1'b1, 0, 0);
        send(ps2_pkg::PS2_ACK);
        device_frame(12, 1, 1, 0, 0);
        wait_drain();

        // Reset mid-DATA, then a clean 0xF0 frame (four ones -> parity 1)
        send(ps2_pkg::PS2_CMD_SET_LED);
        device_frame(12, 1, 0, 0, 1);
        repeat (10) @(negedge clk);
        push(0, 1, 8'hF0, 1'b1, 0, 0);
        send(ps2_pkg::PS2_BREAK);
        device_frame(12, 1, 0, 0, 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
